// File: rtl/wrr_stream_arbiter_if.sv
// Stream bundle for wrr_stream_arbiter: per-channel FWFT read sides in, one write stream out.
// The master modport is the arbiter side. The slave modport is the environment (FIFOs and downstream).
interface wrr_stream_arbiter_if #(
    parameter int CHANNELS = 5,
    parameter int DWIDTH   = 32
);
    localparam int IDW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]        CH_ENABLE;
    logic [CHANNELS-1:0]        WRITE_REQ;
    logic [CHANNELS-1:0]        HOLD_REQ;
    logic [CHANNELS*DWIDTH-1:0] DATA_IN;
    logic [CHANNELS-1:0]        READ_GRANT;
    logic                       READY_OUT;
    logic                       WRITE_OUT;
    logic [DWIDTH-1:0]          DATA_OUT;
    logic [IDW-1:0]             GRANT_ID;
    logic                       BUSY;

    modport master (
        input  CH_ENABLE, WRITE_REQ, HOLD_REQ, DATA_IN, READY_OUT,
        output READ_GRANT, WRITE_OUT, DATA_OUT, GRANT_ID, BUSY
    );

    modport slave (
        output CH_ENABLE, WRITE_REQ, HOLD_REQ, DATA_IN, READY_OUT,
        input  READ_GRANT, WRITE_OUT, DATA_OUT, GRANT_ID, BUSY
    );
endinterface

// File: rtl/wrr_stream_arbiter.sv
// N-channel burst round-robin arbiter merging FWFT FIFO read sides into one registered write stream.
// Optional macro WRR_ARB_TAG_EN replaces the top IDW bits of DATA_OUT with the source channel index.
module wrr_arb_lane #(
    parameter int DWIDTH = 32
) (
    input  logic              en,
    input  logic              wreq,
    input  logic              hold,
    input  logic              sel,
    input  logic              ready,
    input  logic [DWIDTH-1:0] din,
    output logic              elig,
    output logic              rg,
    output logic              sel_en,
    output logic              sel_wreq,
    output logic              sel_hold,
    output logic [DWIDTH-1:0] dsel
);
    assign elig     = en & wreq;
    assign rg       = sel & elig & ready;
    assign sel_en   = sel & en;
    assign sel_wreq = sel & wreq;
    assign sel_hold = sel & hold;
    assign dsel     = sel ? din : '0;
endmodule

module wrr_stream_arbiter #(
    parameter int CHANNELS = 5,
    parameter int DWIDTH   = 32,
    parameter int BURST    = 16
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    wrr_stream_arbiter_if.master bus
);
    localparam int IDW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW  = $clog2(BURST) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                            state, state_nxt;
    logic [IDW-1:0]                    cur, ptr, pick;
    logic                              found;
    logic [CW-1:0]                     cnt, cnt_nxt;
    logic                              take, rd, last;
    logic                              cur_en, cur_wreq, cur_hold;
    logic [CHANNELS-1:0]               sel, elig, rg;
    logic [CHANNELS-1:0]               sel_en, sel_wreq, sel_hold;
    logic [CHANNELS-1:0][DWIDTH-1:0]   dsel;
    logic [DWIDTH-1:0]                 word, word_out;
    logic                              wr_q;
    logic [DWIDTH-1:0]                 data_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        assign sel[i] = (state == GRANT) && (cur == IDW'(i));
        wrr_arb_lane #(.DWIDTH(DWIDTH)) u_lane (
            .en       (bus.CH_ENABLE[i]),
            .wreq     (bus.WRITE_REQ[i]),
            .hold     (bus.HOLD_REQ[i]),
            .sel      (sel[i]),
            .ready    (bus.READY_OUT),
            .din      (bus.DATA_IN[i*DWIDTH +: DWIDTH]),
            .elig     (elig[i]),
            .rg       (rg[i]),
            .sel_en   (sel_en[i]),
            .sel_wreq (sel_wreq[i]),
            .sel_hold (sel_hold[i]),
            .dsel     (dsel[i])
        );
    end

    assign cur_en   = |sel_en;
    assign cur_wreq = |sel_wreq;
    assign cur_hold = |sel_hold;
    assign rd       = |rg;
    assign last     = (cnt == CW'(BURST - 1));

    // sel is one-hot in GRANT, so OR-ing the gated lane words is the mux
    always_comb begin
        word = '0;
        for (int i = 0; i < CHANNELS; i++) word = word | dsel[i];
    end

`ifdef WRR_ARB_TAG_EN
    assign word_out = {cur, word[DWIDTH-IDW-1:0]};
`else
    assign word_out = word;
`endif

    // First eligible channel strictly after ptr; ptr+1+k < 2*CHANNELS so one subtract wraps it
    always_comb begin
        logic [IDW:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k + 1);
            if (idx >= (IDW+1)'(CHANNELS)) idx = idx - (IDW+1)'(CHANNELS);
            if (!found && elig[idx[IDW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    take      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // saturate at BURST-1: only reachable past the limit while HOLD_REQ is set
                if (rd && !last) cnt_nxt = cnt + CW'(1);
                if (!cur_en || (!cur_hold && (!cur_wreq || (rd && last))))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
            cnt   <= '0;
            cur   <= '0;
            ptr   <= IDW'(CHANNELS - 1);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (take) begin
                cur <= pick;
                ptr <= pick;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_q   <= 1'b0;
            data_q <= '0;
        end else begin
            wr_q <= rd;
            if (rd) data_q <= word_out;
        end
    end

    assign bus.READ_GRANT = rg;
    assign bus.WRITE_OUT  = wr_q;
    assign bus.DATA_OUT   = data_q;
    assign bus.GRANT_ID   = cur;
    assign bus.BUSY       = (state == GRANT);
endmodule

// File: tb/tb_wrr_stream_arbiter.sv
// Self-checking bench for wrr_stream_arbiter: directed scenarios plus a random phase, checked
// against a grant-level reference model (rotation by modulo search, words-per-grant accounting).
module tb_wrr_stream_arbiter;
    localparam int C     = 5;
    localparam int DW    = 32;
    localparam int BURST = 4;
    localparam int IDW   = 3;

    logic CLK = 1'b0;
    logic RSTn;
    always #5 CLK = ~CLK;

    wrr_stream_arbiter_if #(.CHANNELS(C), .DWIDTH(DW)) bus ();
    wrr_stream_arbiter #(.CHANNELS(C), .DWIDTH(DW), .BURST(BURST)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    int passed = 0, total = 0, fails = 0;

    bit             m_busy, m_wo;
    int             m_cur, m_ptr, m_cnt, m_gid;
    logic [DW-1:0]  m_do;
    int             m_reads [C];
    int             obs_ch [C];
    int             obs_rd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_busy = 0; m_wo = 0; m_cur = 0; m_ptr = C - 1; m_cnt = 0; m_gid = 0; m_do = '0;
    endtask

    task automatic clr();
        obs_rd = 0;
        for (int i = 0; i < C; i++) begin obs_ch[i] = 0; m_reads[i] = 0; end
    endtask

    task automatic rand_data();
        for (int i = 0; i < C; i++) bus.DATA_IN[i*DW +: DW] = $urandom;
    endtask

    task automatic drive(input logic [C-1:0] en, input logic [C-1:0] wreq,
                         input logic [C-1:0] hold, input logic ready);
        bus.CH_ENABLE = en; bus.WRITE_REQ = wreq; bus.HOLD_REQ = hold; bus.READY_OUT = ready;
    endtask

    // Called just after a falling edge with inputs applied; checks, advances the model, one cycle.
    task automatic step();
        logic [C-1:0]  erg;
        logic [DW-1:0] w;
        bit            rd, done;
        int            c;
        #1;
        erg = '0;
        if (m_busy && bus.WRITE_REQ[m_cur] && bus.READY_OUT && bus.CH_ENABLE[m_cur]) erg[m_cur] = 1'b1;
        check("read_grant", bus.READ_GRANT, erg);
        check("busy",       bus.BUSY, m_busy);
        check("grant_id",   bus.GRANT_ID, m_gid);
        check("write_out",  bus.WRITE_OUT, m_wo);
        check("data_out",   bus.DATA_OUT, m_do);
        for (int i = 0; i < C; i++) if (bus.READ_GRANT[i]) begin obs_ch[i]++; obs_rd++; end
        if (!m_busy) begin
            m_wo = 0;
            for (int k = 1; k <= C; k++) begin
                c = (m_ptr + k) % C;
                if (bus.WRITE_REQ[c] && bus.CH_ENABLE[c]) begin
                    m_cur = c; m_ptr = c; m_gid = c; m_cnt = 0; m_busy = 1;
                    break;
                end
            end
        end else begin
            rd   = erg[m_cur];
            m_wo = rd;
            if (rd) begin
                w = bus.DATA_IN[m_cur*DW +: DW];
`ifdef WRR_ARB_TAG_EN
                w[DW-1 -: IDW] = IDW'(m_cur);
`endif
                m_do = w;
                m_cnt++;
                m_reads[m_cur]++;
            end
            done = !bus.CH_ENABLE[m_cur] ||
                   (!bus.HOLD_REQ[m_cur] && !bus.WRITE_REQ[m_cur]) ||
                   (rd && !bus.HOLD_REQ[m_cur] && m_cnt >= BURST);
            if (done) m_busy = 0;
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic flush();
        drive('1, '0, '0, 1'b1);
        repeat (3) step();
    endtask

    initial begin
        RSTn = 1'b0;
        drive('0, '0, '0, 1'b0);
        bus.DATA_IN = '0;
        m_reset();
        clr();
        repeat (2) @(negedge CLK);
        #1;
        check("rst_read_grant", bus.READ_GRANT, 0);
        check("rst_write_out",  bus.WRITE_OUT, 0);
        check("rst_data_out",   bus.DATA_OUT, 0);
        check("rst_grant_id",   bus.GRANT_ID, 0);
        check("rst_busy",       bus.BUSY, 0);
        @(negedge CLK);
        RSTn = 1'b1;

        // 1: two channels, full-rate bursts of 4 with one-cycle bubbles
        clr();
        drive(5'b00101, 5'b00101, '0, 1'b1);
        repeat (15) begin rand_data(); step(); end
        check("t1_reads", obs_rd, 12);
        check("t1_ch0",   obs_ch[0], 8);
        check("t1_ch2",   obs_ch[2], 4);

        // 2: back-pressure mid-burst on ch1
        clr();
        drive('1, 5'b00010, '0, 1'b1);
        repeat (3) begin rand_data(); step(); end
        bus.READY_OUT = 1'b0;
        repeat (3) begin rand_data(); step(); end
        check("t2_stalled_reads", obs_ch[1], 2);
        bus.READY_OUT = 1'b1;
        repeat (2) begin rand_data(); step(); end
        check("t2_ch1", obs_ch[1], 4);
        flush();

        // 3: hold lock on ch1 for 10 words with a 2-cycle gap, ch0 waiting
        clr();
        drive('1, 5'b00010, 5'b00010, 1'b1);
        rand_data(); step();
        bus.WRITE_REQ = 5'b00011;
        for (int n = 0; n < 20 && m_reads[1] < 5; n++) begin rand_data(); step(); end
        bus.WRITE_REQ = 5'b00001;
        repeat (2) begin rand_data(); step(); end
        bus.WRITE_REQ = 5'b00011;
        for (int n = 0; n < 20 && m_reads[1] < 10; n++) begin rand_data(); step(); end
        check("t3_ch1", obs_ch[1], 10);
        check("t3_no_ch0", obs_ch[0], 0);
        drive('1, 5'b00001, '0, 1'b1);
        repeat (3) begin rand_data(); step(); end
        check("t3_ch0_after", obs_ch[0], 1);
        flush();

        // 4: ch0 masked off
        clr();
        drive(5'b11110, 5'b11111, '0, 1'b1);
        repeat (25) begin rand_data(); step(); end
        check("t4_ch0_never", obs_ch[0], 0);
        check("t4_ch1", obs_ch[1], 8);
        flush();

        // 5: async reset mid-burst on ch3
        clr();
        drive('1, 5'b01000, '0, 1'b1);
        repeat (2) begin rand_data(); step(); end
        #2;
        RSTn = 1'b0;
        #1;
        check("t5_read_grant", bus.READ_GRANT, 0);
        check("t5_write_out",  bus.WRITE_OUT, 0);
        check("t5_busy",       bus.BUSY, 0);
        check("t5_grant_id",   bus.GRANT_ID, 0);
        m_reset();
        clr();
        bus.WRITE_REQ = 5'b11111;
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (2) begin rand_data(); step(); end
        check("t5_first_ch0", obs_ch[0], 1);
        flush();

        // 6: all-ones word on ch3
        drive('1, 5'b01000, '0, 1'b1);
        rand_data();
        bus.DATA_IN[3*DW +: DW] = 32'hFFFF_FFFF;
        repeat (2) step();
`ifdef WRR_ARB_TAG_EN
        check("t6_data", bus.DATA_OUT, 32'h7FFF_FFFF);
`else
        check("t6_data", bus.DATA_OUT, 32'hFFFF_FFFF);
`endif
        flush();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < C; i++) begin
                bus.WRITE_REQ[i] = ($urandom_range(9) < 7);
                bus.HOLD_REQ[i]  = ($urandom_range(9) == 0);
                bus.CH_ENABLE[i] = ($urandom_range(15) != 0);
            end
            bus.READY_OUT = ($urandom_range(4) != 0);
            rand_data();
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/wrr_stream_arbiter.md
Name: wrr_stream_arbiter

Overview:
Parametrised N-channel burst round-robin arbiter. Merges several first-word-fall-through (FWFT) FIFO read sides, such as front-end RX FIFOs and the TDC FIFO, into one registered write stream toward the data FIFO.
Generalises the fixed per-word round-robin arbiter:
- per-channel enable mask;
- configurable burst quota per grant;
- hold/packet lock that overrides the quota;
- grant status outputs.
Sits between the per-channel FIFOs and the output width converter, in the CLK domain.

Parameters:
CHANNELS, 5, number of input channels; legal range 1..32.
DWIDTH, 32, data word width.
BURST, 16, maximum words read per grant; legal range 1..256. BURST=1 gives pure per-word round robin.
IDW, $clog2(CHANNELS) (min 1), width of GRANT_ID and tag field. Derived localparam, not overridable.

Ports:
CLK  in  1  single clock for all logic.
RSTn  in  1  asynchronous active-low reset.
CH_ENABLE  in  CHANNELS  per-channel enable mask; 0 = channel never granted.
WRITE_REQ  in  CHANNELS  channel i has data (its FIFO is not empty).
HOLD_REQ  in  CHANNELS  channel i requests grant lock (packet in progress).
DATA_IN  in  CHANNELS*DWIDTH  channel i word at [i*DWIDTH +: DWIDTH]; FWFT, valid while WRITE_REQ[i]=1.
READ_GRANT  out  CHANNELS  one-hot read strobe to channel i's FIFO.
READY_OUT  in  1  downstream can accept a word (downstream FIFO not full).
WRITE_OUT  out  1  registered write strobe to downstream.
DATA_OUT  out  DWIDTH  registered data word.
GRANT_ID  out  IDW  index of the currently or last granted channel.
BUSY  out  1  1 while in the GRANT state.

Behaviour:
- Reset (async, RSTn=0):
  - state=IDLE, burst counter=0, last-grant pointer=CHANNELS-1 (so the first search starts at channel 0);
  - WRITE_OUT=0, DATA_OUT=0, GRANT_ID=0, BUSY=0;
  - READ_GRANT=0 immediately, because it is decoded from state.
- Eligible set: elig[i] = WRITE_REQ[i] & CH_ENABLE[i].
- IDLE state:
  - If elig≠0, select the first eligible index strictly after the last-grant pointer, wrapping modulo CHANNELS.
  - On selection: latch cur, GRANT_ID=cur, pointer=cur, counter=0, go to GRANT. BUSY=1 from the next cycle.
  - No READ_GRANT is issued in IDLE (one-cycle arbitration bubble).
- GRANT state:
  - READ_GRANT[cur] = WRITE_REQ[cur] & READY_OUT & CH_ENABLE[cur]. All other bits are 0. The term is combinational.
  - On each read: counter+1. Next cycle WRITE_OUT=1 and DATA_OUT=DATA_IN[cur] as sampled at the read cycle. Latency is 1 cycle.
  - When no read occurs: WRITE_OUT=0 next cycle and DATA_OUT holds its value.
- Exit GRANT → IDLE at the end of the cycle in which any of the following holds:
  - (a) a read occurs with counter==BURST-1 and HOLD_REQ[cur]=0;
  - (b) WRITE_REQ[cur]=0 and HOLD_REQ[cur]=0;
  - (c) CH_ENABLE[cur]=0. This exits regardless of HOLD_REQ.
- HOLD_REQ[cur]=1:
  - grant stays on cur even when WRITE_REQ[cur] gaps;
  - burst limit is ignored and the counter saturates at BURST-1.
- READY_OUT=0 mid-burst: no read, counter holds, stay in GRANT. A channel is never abandoned because of back-pressure.
- Counter width is $clog2(BURST)+1 bits; it never wraps.
- HOLD_REQ on a channel not currently granted has no effect on selection.
- Single eligible channel: re-granted after each bubble. Steady-state throughput is BURST/(BURST+1) words per cycle.
- CH_ENABLE or WRITE_REQ changes while in IDLE: selection uses the values in the cycle of the decision.

Optional Feature:
WRR_ARB_TAG_EN
- Defined: DATA_OUT[DWIDTH-1 -: IDW] = channel index of the word; the remaining bits are the input word's low DWIDTH-IDW bits. Requires DWIDTH > IDW.
- Undefined: DATA_OUT equals the input word unchanged.

Test Plan:
1. BURST=4; ch0 and ch2 enabled and requesting continuously; READY_OUT=1 -> reads in order: 4×ch0, bubble, 4×ch2, bubble, 4×ch0; WRITE_OUT high for 4 of every 5 cycles.
2. BURST=4; READY_OUT=0 for 3 cycles after the 2nd read of ch1 -> READ_GRANT=0 for those 3 cycles, BUSY stays 1, then exactly 2 more ch1 reads before exit.
3. BURST=4; ch1 with HOLD_REQ=1, pushing 10 words with a 2-cycle WRITE_REQ gap, ch0 also requesting -> 10 consecutive ch1 words with no ch0 interleave; ch0 granted after the bubble following HOLD_REQ release.
4. CH_ENABLE=5'b11110, all WRITE_REQ=1 -> READ_GRANT[0] never asserts; grants rotate 1,2,3,4,1.
5. RSTn pulsed low mid-burst on ch3 -> READ_GRANT, WRITE_OUT, BUSY, GRANT_ID go to 0 without a clock edge; after release with all channels requesting, first grant is ch0.
6. CHANNELS=5, DWIDTH=32; ch3 DATA_IN=32'hFFFFFFFF -> with WRR_ARB_TAG_EN, DATA_OUT=32'h7FFFFFFF; without it, DATA_OUT=32'hFFFFFFFF.
